// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (div.w/mod.w/div.wu/mod.wu) with valid/ready handshake.
// Define DIV_EARLY_OUT_EN to skip iteration when b=0 or |b|>|a|.
module div_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        remsel_q, remsel_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        bz_q, bz_d;

    logic        accept, is_signed, sa, sb, early;
    logic [31:0] mag_a, mag_b, quot, rem;
    logic [32:0] rem_shift, diff;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    always_comb begin
        is_signed = ~op[1];
        sa        = is_signed & a[31];
        sb        = is_signed & b[31];
        // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
        mag_a     = sa ? neg32(a) : a;
        mag_b     = sb ? neg32(b) : b;
        accept    = in_valid & in_ready;
`ifdef DIV_EARLY_OUT_EN
        early     = (b == 32'd0) || (mag_b > mag_a);
`else
        early     = 1'b0;
`endif
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            remsel_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            remsel_q <= remsel_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = early ? DONE : CALC;
                CALC:    if (cnt_q == 5'd31) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        remsel_d = remsel_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        if (accept) begin
            cnt_d    = 5'd0;
            dvs_d    = mag_b;
            remsel_d = op[0];
            sa_d     = sa;
            sb_d     = sb;
            bz_d     = (b == 32'd0);
            if (early) begin
                quo_d = (b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                rem_d = mag_a;
            end else begin
                quo_d = mag_a;
                rem_d = 32'd0;
            end
        end else if (state_q == CALC) begin
            // quo_q shifts the dividend out at the top and the quotient bits in at the bottom.
            cnt_d = cnt_q + 5'd1;
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_shift[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        quot      = ((sa_q ^ sb_q) & ~bz_q) ? neg32(quo_q) : quo_q;
        rem       = sa_q ? neg32(rem_q) : rem_q;
        out_valid = (state_q == DONE);
        in_ready  = (state_q == IDLE) & ~flush;
        busy      = (state_q != IDLE);
        y         = out_valid ? (remsel_q ? rem : quot) : 32'd0;
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: accepts push reference results, a negedge monitor checks outputs.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic        busy;

    div_unit dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   seen = 1'b0;
    bit   idle_chk = 1'b0;
    bit   rnd_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint sval(input logic [1:0] o, input logic [31:0] x);
        longint v;
        if (!o[1]) v = longint'($signed(x));
        else       v = {32'd0, x};
        return v;
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] z);
        longint qq, rr;
        if (z == 32'd0) return o[0] ? x : 32'hFFFF_FFFF;
        qq = sval(o, x) / sval(o, z);
        rr = sval(o, x) % sval(o, z);
        return o[0] ? rr[31:0] : qq[31:0];
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [31:0] x, input logic [31:0] z);
`ifdef DIV_EARLY_OUT_EN
        longint ma, mb;
        ma = sval(o, x);
        mb = sval(o, z);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (z == 32'd0 || mb > ma) return 1;
`endif
        return 33;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            sb.delete();
            seen = 1'b0;
            idle_chk = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_y", y, 0);
            chk("rst_busy", busy, 0);
        end else begin
            if (idle_chk) begin
                chk("idle_after_xfer", busy, 0);
                idle_chk = 1'b0;
            end
            if (!out_valid) chk("y_zero_when_invalid", y, 0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc - sb[0].acc, sb[0].lat);
                        seen = 1'b1;
                    end
                    chk("y", y, sb[0].y);
                    chk("in_ready_in_done", in_ready, 0);
                    if (!flush && out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                        idle_chk = 1'b1;
                    end
                end
            end
            if (flush) begin
                if (sb.size() != 0) void'(sb.pop_front());
                seen = 1'b0;
                chk("in_ready_during_flush", in_ready, 0);
            end
            if (in_valid && in_ready) begin
                e.y   = model(op, a, b);
                e.acc = cyc;
                e.lat = lat_of(op, a, b);
                sb.push_back(e);
            end
        end
    end

    // Called at posedge+1 with the unit idle; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] z);
        op = o;
        a = x;
        b = z;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        out_ready = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] z);
        issue(o, x, z);
        wait_done(80);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 255);
            5:       return 32'hFFFF_FFFF - $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        run(2'b00, 32'd100, 32'd7);
        run(2'b01, 32'd100, 32'd7);
        run(2'b01, 32'hFFFF_FFF9, 32'd2);
        run(2'b00, 32'hFFFF_FFF9, 32'd2);
        run(2'b10, 32'hFFFF_FFFF, 32'd2);
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b00, 32'd5, 32'd0);
        run(2'b11, 32'd5, 32'd0);
        run(2'b01, 32'hFFFF_FFF9, 32'd0);
        run(2'b00, 32'd3, 32'd10);

        // Flush ten cycles after accept, then accept again right away.
        issue(2'b00, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("idle_after_flush", busy, 0);
        issue(2'b01, 32'd1000, 32'd3);
        wait_done(80);

        // Writeback stalls five cycles in DONE.
        out_ready = 1'b0;
        issue(2'b10, 32'd12345, 32'd67);
        wait_valid(80);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(10);

        // Flush with out_ready high in DONE is not a transfer.
        out_ready = 1'b0;
        issue(2'b00, 32'd77, 32'd7);
        wait_valid(80);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("idle_after_done_flush", busy, 0);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-CALC and mid-DONE.
        issue(2'b00, 32'd999, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("in_ready_after_calc_reset", in_ready, 1);
        repeat (40) @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(2'b11, 32'd999, 32'd9);
        wait_valid(80);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        chk("in_ready_after_done_reset", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;

        rnd_rdy = 1'b1;
        for (int i = 0; i < 60; i++) run(2'($urandom), pick(), pick());
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
